// File: rtl/proc_pkg.sv
// Shared definitions for the proc_core processor: opcodes, FSM states and
// instruction field positions.
package proc_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_DIV   = 5'd2,
    OP_MUL   = 5'd3,
    OP_MOD   = 5'd4,
    OP_SIL   = 5'd5,
    OP_SIE   = 5'd6,
    OP_COPY  = 5'd7,
    OP_JMP   = 5'd8,
    OP_LOAD  = 5'd9,
    OP_STORE = 5'd10,
    OP_SET   = 5'd11,
    OP_HALT  = 5'd12
  } opcode_e;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    NEXT,
    HALT
  } state_e;

  localparam int unsigned OPC_HI   = 31;
  localparam int unsigned OPC_LO   = 27;
  localparam int unsigned R1_HI    = 26;
  localparam int unsigned R1_LO    = 24;
  localparam int unsigned R2_HI    = 23;
  localparam int unsigned R2_LO    = 21;
  localparam int unsigned R3_HI    = 20;
  localparam int unsigned R3_LO    = 18;
  localparam int unsigned IMM_HI   = 23;
  localparam int unsigned IMM_LO   = 8;
  localparam int unsigned NUM_REGS = 8;

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU for proc_core: unsigned arithmetic modulo 2^DATA_W.
module proc_alu
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  // Result select; division/modulo by zero yield all-ones / a respectively.
  always_comb begin
    y = '0;
    case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_DIV: y = (b == '0) ? '1 : a / b;
      OP_MUL: y = a * b;
      OP_MOD: y = (b == '0) ? a : a % b;
      OP_SIL: y = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_SIE: y = {{(DATA_W-1){1'b0}}, (a == b)};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/proc_core.sv
// Multi-cycle processor core: FETCH/DECODE/EXEC/MEM/NEXT/HALT sequencer with
// an 8-entry register file and a single request/ack memory port.
module proc_core
  import proc_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_halted,
  output logic              o_illegal,
  output logic [31:0]       o_retired
);

  state_e state, state_n;

  // The low byte of an instruction carries no field, so it is not kept.
  logic [31:IMM_LO]  instr;
  logic [DATA_W-1:0] regs [NUM_REGS];

  opcode_e           opcode;
  logic [2:0]        r1, r2, r3;
  logic [15:0]       imm16;
  logic [ADDR_W-1:0] imm_addr, pc_next;
  logic [DATA_W-1:0] rd1, rd2, alu_y;

  logic              req_n, we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;
  logic              ir_we, rf_we, pc_adv, retire, illegal_set;
  logic [2:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  assign opcode   = opcode_e'(instr[OPC_HI:OPC_LO]);
  assign r1       = instr[R1_HI:R1_LO];
  assign r2       = instr[R2_HI:R2_LO];
  assign r3       = instr[R3_HI:R3_LO];
  assign imm16    = instr[IMM_HI:IMM_LO];
  assign imm_addr = imm16[ADDR_W-1:0];
  assign rd1      = regs[r1];
  assign rd2      = regs[r2];
  assign o_halted = (state == HALT);

  // jmp leaves the register file untouched, so the condition is still valid in NEXT.
  assign pc_next = (opcode == OP_JMP && rd1[0]) ? imm_addr : o_pc + 1'b1;

  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .op (opcode),
    .a  (rd1),
    .b  (rd2),
    .y  (alu_y)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= FETCH;
    else         state <= state_n;
  end

  // Next state and datapath strobes. Memory outputs are registered: the
  // request for the next access is raised on the edge leaving NEXT/DECODE,
  // so only the very first fetch after reset spends an extra cycle raising it.
  always_comb begin
    state_n     = state;
    req_n       = o_mem_req;
    we_n        = o_mem_we;
    addr_n      = o_mem_addr;
    wdata_n     = o_mem_wdata;
    ir_we       = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = r1;
    rf_wdata    = '0;
    pc_adv      = 1'b0;
    retire      = 1'b0;
    illegal_set = 1'b0;
    case (state)
      FETCH: begin
        if (!o_mem_req) begin
          req_n  = 1'b1;
          we_n   = 1'b0;
          addr_n = o_pc;
        end else if (i_mem_ack) begin
          req_n   = 1'b0;
          ir_we   = 1'b1;
          state_n = DECODE;
        end
      end
      DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_DIV, OP_MUL, OP_MOD, OP_SIL, OP_SIE: state_n = EXEC;
          OP_LOAD, OP_STORE: begin
            req_n   = 1'b1;
            we_n    = (opcode == OP_STORE);
            addr_n  = imm_addr;
            wdata_n = (opcode == OP_STORE) ? rd1 : o_mem_wdata;
            state_n = MEM;
          end
          OP_COPY: begin
            rf_we    = 1'b1;
            rf_wdata = rd2;
            state_n  = NEXT;
          end
          OP_SET: begin
            rf_we    = 1'b1;
            rf_wdata = {{(DATA_W-16){1'b0}}, imm16};
            state_n  = NEXT;
          end
          OP_JMP:  state_n = NEXT;
          OP_HALT: begin
            retire  = 1'b1;
            state_n = HALT;
          end
          default: begin
            illegal_set = 1'b1;
            state_n     = HALT;
          end
        endcase
      end
      EXEC: begin
        rf_we    = 1'b1;
        rf_waddr = r3;
        rf_wdata = alu_y;
        state_n  = NEXT;
      end
      MEM: begin
        if (i_mem_ack) begin
          req_n    = 1'b0;
          we_n     = 1'b0;
          rf_we    = !o_mem_we;
          rf_wdata = i_mem_rdata;
          state_n  = NEXT;
        end
      end
      NEXT: begin
        pc_adv  = 1'b1;
        retire  = 1'b1;
        req_n   = 1'b1;
        we_n    = 1'b0;
        addr_n  = pc_next;
        state_n = FETCH;
      end
      HALT: state_n = HALT;
      default: state_n = FETCH;
    endcase
  end

  // Datapath registers: memory port, instruction, register file, pc, counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      instr       <= '0;
      o_pc        <= RESET_PC;
      o_retired   <= '0;
      o_illegal   <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      o_mem_req   <= req_n;
      o_mem_we    <= we_n;
      o_mem_addr  <= addr_n;
      o_mem_wdata <= wdata_n;
      if (ir_we)       instr <= i_mem_rdata[31:IMM_LO];
      if (rf_we)       regs[rf_waddr] <= rf_wdata;
      if (pc_adv)      o_pc <= pc_next;
      if (retire)      o_retired <= o_retired + 32'd1;
      if (illegal_set) o_illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_proc_core.sv
// Self-checking bench for proc_core: memory responder with random ack delay,
// ISA-level reference interpreter, and directed scenario tasks.
module tb_proc_core;

  localparam logic [15:0] BASE = 16'h0008;
  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, DIVI = 5'd2, MUL = 5'd3, MODI = 5'd4,
                         SIL = 5'd5, SIE = 5'd6, CPY = 5'd7, JMP = 5'd8, LD = 5'd9,
                         STO = 5'd10, SETI = 5'd11, HLT = 5'd12;

  logic        clk = 1'b0, rst = 1'b0;
  logic        mem_req, mem_we, ack = 1'b0, halted, illegal;
  logic [15:0] mem_addr, pc;
  logic [31:0] mem_wdata, rdata = '0, retired;

  int tests = 0, fails = 0, cyc = 0;
  int max_delay = 0, stall_addr = -1;

  logic [31:0] mem [0:65535];
  logic [31:0] model_mem [0:65535];
  logic [31:0] img [0:1023];
  logic [31:0] model_regs [0:7];
  int          model_retired;
  bit          model_illegal;
  logic [16:0] req_log [$];
  int          req_cyc [$];

  proc_core #(.DATA_W(32), .ADDR_W(16), .RESET_PC(BASE)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_ack   (ack),
    .i_mem_rdata (rdata),
    .o_pc        (pc),
    .o_halted    (halted),
    .o_illegal   (illegal),
    .o_retired   (retired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] enc_r(logic [4:0] op, logic [2:0] a, logic [2:0] b, logic [2:0] c);
    return {op, a, b, c, 18'd0};
  endfunction

  function automatic logic [31:0] enc_i(logic [4:0] op, logic [2:0] a, logic [15:0] imm);
    return {op, a, imm, 8'd0};
  endfunction

  // Memory responder: random wait per access, logs requests, checks stability.
  initial begin : responder
    bit          pending = 0;
    int          cnt = 0;
    logic [15:0] r_addr = '0;
    logic        r_we = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        ack = 1'b0;
        pending = 0;
      end else begin
        if (ack) begin
          ack = 1'b0;
          pending = 0;
        end
        if (mem_req) begin
          if (!pending) begin
            pending = 1;
            r_addr = mem_addr;
            r_we = mem_we;
            cnt = (max_delay > 0) ? int'($urandom_range(max_delay, 0)) : 0;
            req_log.push_back({mem_we, mem_addr});
            req_cyc.push_back(cyc);
          end else begin
            tests++;
            if (mem_addr !== r_addr || mem_we !== r_we) begin
              fails++;
              $display("FAIL req_stable: addr=%h we=%b, required addr=%h we=%b", mem_addr, mem_we, r_addr, r_we);
            end
          end
          if (stall_addr < 0 || int'(mem_addr) != stall_addr) begin
            if (cnt == 0) begin
              ack = 1'b1;
              if (mem_we) mem[mem_addr] = mem_wdata;
              rdata = mem[mem_addr];
            end else begin
              cnt--;
            end
          end
        end
        if (!ack) rdata = $urandom;
      end
    end
  end

  // ISA-level interpreter over model_mem, starting at BASE.
  task automatic model_run();
    logic [15:0] mpc = BASE;
    logic [31:0] w, x, y;
    logic [4:0]  op;
    logic [2:0]  a, b, c;
    logic [15:0] imm;
    for (int i = 0; i < 8; i++) model_regs[i] = '0;
    model_retired = 0;
    model_illegal = 0;
    for (int step = 0; step < 5000; step++) begin
      w = model_mem[mpc];
      op = w[31:27]; a = w[26:24]; b = w[23:21]; c = w[20:18]; imm = w[23:8];
      x = model_regs[a]; y = model_regs[b];
      if (op > 5'd12) begin model_illegal = 1; break; end
      if (op == HLT) begin model_retired++; break; end
      model_retired++;
      mpc = mpc + 16'd1;
      case (op)
        ADD:  model_regs[c] = x + y;
        SUB:  model_regs[c] = x - y;
        DIVI: model_regs[c] = (y == 0) ? 32'hFFFF_FFFF : x / y;
        MUL:  model_regs[c] = x * y;
        MODI: model_regs[c] = (y == 0) ? x : x % y;
        SIL:  model_regs[c] = (x < y) ? 32'd1 : 32'd0;
        SIE:  model_regs[c] = (x == y) ? 32'd1 : 32'd0;
        CPY:  model_regs[a] = y;
        JMP:  if (x[0]) mpc = imm;
        LD:   model_regs[a] = model_mem[imm];
        STO:  model_mem[imm] = x;
        SETI: model_regs[a] = {16'd0, imm};
        default: ;
      endcase
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 1024; i++) img[i] = '0;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 1024; i++) mem[i] = img[i];
  endtask

  task automatic load_model();
    for (int i = 0; i < 1024; i++) model_mem[i] = img[i];
  endtask

  task automatic start_dut(input int dly);
    max_delay = dly;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    req_log.delete();
    req_cyc.delete();
    rst = 1'b0;
  endtask

  task automatic wait_halt(input int budget, input string tag);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (halted === 1'b1) ok = 1;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_halt_timeout: halted=%b after %0d cycles, required 1", tag, halted, budget);
    end
  endtask

  task automatic wait_reqs(input int n, input int budget, input string tag);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (req_log.size() >= n) ok = 1;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_req_timeout: %0d requests seen, required %0d", tag, req_log.size(), n);
    end
  endtask

  task automatic test_reset();
    clear_img();
    img[BASE] = enc_i(HLT, 3'd0, 16'd0);
    load_mem();
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, halted, illegal, retired} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h halted=%b illegal=%b retired=%0d, required all 0",
               mem_req, mem_we, mem_addr, mem_wdata, halted, illegal, retired);
    end
    tests++;
    if (pc !== BASE) begin
      fails++;
      $display("FAIL reset_pc: pc=%h, required %h", pc, BASE);
    end
    repeat (2) @(negedge clk);
    req_log.delete();
    req_cyc.delete();
    rst = 1'b0;
    wait_reqs(1, 10, "reset");
    tests++;
    if (req_log.size() < 1 || req_log[0] !== {1'b0, BASE}) begin
      fails++;
      $display("FAIL reset_first_fetch: got %h, required %h", (req_log.size() > 0) ? req_log[0] : 17'h1ffff, {1'b0, BASE});
    end
    wait_halt(20, "reset");
    tests++;
    if (retired !== 32'd1) begin
      fails++;
      $display("FAIL halt_retires: retired=%0d, required 1", retired);
    end
  endtask

  task automatic test_basic();
    clear_img();
    img[BASE+0] = enc_i(SETI, 3'd1, 16'd5);
    img[BASE+1] = enc_i(SETI, 3'd2, 16'd3);
    img[BASE+2] = enc_r(ADD, 3'd1, 3'd2, 3'd3);
    img[BASE+3] = enc_i(STO, 3'd3, 16'h0040);
    img[BASE+4] = enc_i(HLT, 3'd0, 16'd0);
    load_mem();
    start_dut(0);
    wait_reqs(6, 60, "basic");
    tests++;
    if (retired !== 32'd4) begin
      fails++;
      $display("FAIL basic_retired: retired=%0d, required 4", retired);
    end
    tests++;
    if (mem[16'h0040] !== 32'd8) begin
      fails++;
      $display("FAIL basic_store: mem[40]=%h, required 8", mem[16'h0040]);
    end
    tests++;
    if (req_log.size() < 6 || req_log[4] !== {1'b1, 16'h0040}) begin
      fails++;
      $display("FAIL basic_store_req: store request not a write at 0040");
    end
    tests++;
    if (req_cyc.size() < 6 || req_cyc[1] - req_cyc[0] != 3 || req_cyc[3] - req_cyc[2] != 4 ||
        req_cyc[5] - req_cyc[3] != 4) begin
      fails++;
      $display("FAIL basic_cycles: set/add/store cost %0d/%0d/%0d, required 3/4/4",
               req_cyc[1] - req_cyc[0], req_cyc[3] - req_cyc[2], req_cyc[5] - req_cyc[3]);
    end
    wait_halt(20, "basic");
  endtask

  task automatic test_div_mod();
    clear_img();
    img[BASE+0] = enc_i(SETI, 3'd1, 16'd7);
    img[BASE+1] = enc_i(SETI, 3'd2, 16'd0);
    img[BASE+2] = enc_r(DIVI, 3'd1, 3'd2, 3'd3);
    img[BASE+3] = enc_i(STO, 3'd3, 16'h0050);
    img[BASE+4] = enc_r(MODI, 3'd1, 3'd2, 3'd4);
    img[BASE+5] = enc_i(STO, 3'd4, 16'h0051);
    img[BASE+6] = enc_i(HLT, 3'd0, 16'd0);
    load_mem();
    start_dut(0);
    wait_halt(100, "divmod");
    tests++;
    if (mem[16'h0050] !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL div_by_zero: got %h, required ffffffff", mem[16'h0050]);
    end
    tests++;
    if (mem[16'h0051] !== 32'd7) begin
      fails++;
      $display("FAIL mod_by_zero: got %h, required 7", mem[16'h0051]);
    end
  endtask

  task automatic test_sie_jmp();
    logic [15:0] want [2];
    logic [31:0] want_sie [2];
    want[0] = 16'h0010;
    want[1] = BASE + 16'd5;
    want_sie[0] = 32'd1;
    want_sie[1] = 32'd0;
    for (int k = 0; k < 2; k++) begin
      clear_img();
      img[BASE+0] = enc_i(SETI, 3'd1, 16'd9);
      img[BASE+1] = enc_i(SETI, 3'd2, (k == 0) ? 16'd9 : 16'd8);
      img[BASE+2] = enc_r(SIE, 3'd1, 3'd2, 3'd3);
      img[BASE+3] = enc_i(STO, 3'd3, 16'h0060);
      img[BASE+4] = enc_i(JMP, 3'd3, 16'h0010);
      img[BASE+5] = enc_i(HLT, 3'd0, 16'd0);
      img[16'h0010] = enc_i(HLT, 3'd0, 16'd0);
      load_mem();
      start_dut(0);
      wait_halt(100, "jmp");
      tests++;
      if (mem[16'h0060] !== want_sie[k]) begin
        fails++;
        $display("FAIL sie_result_%0d: got %h, required %h", k, mem[16'h0060], want_sie[k]);
      end
      tests++;
      if (req_log.size() == 0 || req_log[req_log.size()-1] !== {1'b0, want[k]}) begin
        fails++;
        $display("FAIL jmp_target_%0d: last fetch %h, required %h", k,
                 (req_log.size() > 0) ? req_log[req_log.size()-1] : 17'h1ffff, {1'b0, want[k]});
      end
      tests++;
      if (retired !== 32'd6) begin
        fails++;
        $display("FAIL jmp_retired_%0d: retired=%0d, required 6", k, retired);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_dump [24];
    int          exp_ret, dly [2], tgt;
    logic [2:0]  ra, rb, rc;
    logic [15:0] imm;
    dly[0] = 0;
    dly[1] = 5;
    for (int it = 0; it < 5; it++) begin
      clear_img();
      for (int i = 0; i < 16; i++) img[16'h0200 + i] = $urandom;
      for (int k = 0; k < 20; k++) begin
        ra = 3'($urandom); rb = 3'($urandom); rc = 3'($urandom);
        imm = 16'h0200 + 16'($urandom_range(15, 0));
        case ($urandom_range(9, 0))
          0, 1, 2, 3: img[BASE+k] = enc_r(5'($urandom_range(6, 0)), ra, rb, rc);
          4, 9: img[BASE+k] = enc_i(SETI, ra, $urandom_range(1, 0) ? 16'($urandom_range(3, 0)) : 16'($urandom));
          5: img[BASE+k] = enc_r(CPY, ra, rb, rc);
          6: img[BASE+k] = enc_i(LD, ra, imm);
          7: img[BASE+k] = enc_i(STO, ra, imm);
          default: begin
            tgt = k + 1 + int'($urandom_range(3, 0));
            if (tgt > 20) tgt = 20;
            img[BASE+k] = enc_i(JMP, ra, BASE + 16'(tgt));
          end
        endcase
      end
      for (int i = 0; i < 8; i++) img[BASE+20+i] = enc_i(STO, 3'(i), 16'h0300 + 16'(i));
      img[BASE+28] = enc_i(HLT, 3'd0, 16'd0);
      load_model();
      model_run();
      for (int i = 0; i < 8; i++) exp_dump[i] = model_mem[16'h0300 + i];
      for (int i = 0; i < 16; i++) exp_dump[8+i] = model_mem[16'h0200 + i];
      exp_ret = model_retired;
      for (int r = 0; r < 2; r++) begin
        load_mem();
        start_dut(dly[r]);
        wait_halt(3000, "random");
        for (int i = 0; i < 24; i++) begin
          tests++;
          if (mem[(i < 8) ? 16'h0300 + i : 16'h0200 + i - 8] !== exp_dump[i]) begin
            fails++;
            $display("FAIL random_state it%0d dly%0d word%0d: got %h, required %h", it, dly[r], i,
                     mem[(i < 8) ? 16'h0300 + i : 16'h0200 + i - 8], exp_dump[i]);
          end
        end
        tests++;
        if (retired !== 32'(exp_ret)) begin
          fails++;
          $display("FAIL random_retired it%0d dly%0d: got %0d, required %0d", it, dly[r], retired, exp_ret);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [4:0] ops [2];
    int         n;
    ops[0] = 5'd13;
    ops[1] = 5'd31;
    for (int k = 0; k < 2; k++) begin
      clear_img();
      img[BASE+0] = enc_i(SETI, 3'd1, 16'd1);
      img[BASE+1] = {ops[k], 27'd0};
      img[BASE+2] = enc_i(SETI, 3'd2, 16'd2);
      img[BASE+3] = enc_i(HLT, 3'd0, 16'd0);
      load_mem();
      start_dut(2);
      wait_halt(100, "illegal");
      tests++;
      if (illegal !== 1'b1 || halted !== 1'b1) begin
        fails++;
        $display("FAIL illegal_flags_op%0d: illegal=%b halted=%b, required 1 1", ops[k], illegal, halted);
      end
      tests++;
      if (retired !== 32'd1) begin
        fails++;
        $display("FAIL illegal_retired_op%0d: retired=%0d, required 1", ops[k], retired);
      end
      n = req_log.size();
      repeat (20) @(negedge clk);
      tests++;
      if (req_log.size() != n || mem_req !== 1'b0) begin
        fails++;
        $display("FAIL illegal_quiet_op%0d: requests %0d->%0d req=%b, required none", ops[k], n, req_log.size(), mem_req);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    clear_img();
    img[BASE+0] = enc_i(LD, 3'd1, 16'h0030);
    img[BASE+1] = enc_i(HLT, 3'd0, 16'd0);
    img[16'h0030] = 32'h1234_5678;
    load_mem();
    stall_addr = 16'h0030;
    start_dut(0);
    wait_reqs(2, 20, "midload");
    repeat (3) @(negedge clk);
    tests++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0030) begin
      fails++;
      $display("FAIL midload_pending: req=%b we=%b addr=%h, required 1 0 0030", mem_req, mem_we, mem_addr);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, halted, illegal, retired} !== '0 || pc !== BASE) begin
      fails++;
      $display("FAIL midload_reset: req=%b we=%b addr=%h pc=%h retired=%0d, required 0 0 0000 %h 0",
               mem_req, mem_we, mem_addr, pc, retired, BASE);
    end
    stall_addr = -1;
    @(negedge clk);
    req_log.delete();
    req_cyc.delete();
    rst = 1'b0;
    wait_reqs(1, 10, "midload_refetch");
    tests++;
    if (req_log.size() < 1 || req_log[0] !== {1'b0, BASE}) begin
      fails++;
      $display("FAIL midload_refetch: first request %h, required %h",
               (req_log.size() > 0) ? req_log[0] : 17'h1ffff, {1'b0, BASE});
    end
    wait_halt(50, "midload");
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = '0;
      model_mem[i] = '0;
    end
    test_reset();
    test_basic();
    test_div_mod();
    test_sie_jmp();
    test_random();
    test_illegal();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
